// File: rtl/vregfile_stride_mp_if.sv
// Bus bundle for the stride register file: read ports, write port,
// clear request and busy status.
interface vregfile_stride_mp_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LOG2NUMREGS = 3,
    parameter int unsigned NUMRPORTS   = 2
);
    logic [NUMRPORTS*LOG2NUMREGS-1:0] a_reg;
    logic [NUMRPORTS-1:0]             a_en;
    logic [NUMRPORTS*WIDTH-1:0]       a_readdataout;
    logic [LOG2NUMREGS-1:0]           c_reg;
    logic [WIDTH-1:0]                 c_writedatain;
    logic                             c_we;
    logic                             clr_req;
    logic                             busy;

    modport master (
        output a_reg, a_en, c_reg, c_writedatain, c_we, clr_req,
        input  a_readdataout, busy
    );

    modport slave (
        input  a_reg, a_en, c_reg, c_writedatain, c_we, clr_req,
        output a_readdataout, busy
    );
endinterface

// File: rtl/vregfile_stride_mp.sv
// Multi-port stride register file with optional write-to-read bypass and a
// clear sequencer that fills every entry with CLEARVAL after reset or on request.
module vregfile_stride_mp #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      NUMREGS     = 8,
    parameter int unsigned      LOG2NUMREGS = 3,
    parameter int unsigned      NUMRPORTS   = 2,
    parameter bit               BYPASS      = 1'b0,
    parameter logic [WIDTH-1:0] CLEARVAL    = '0
) (
    input logic                 clk,
    input logic                 reset,
    vregfile_stride_mp_if.slave bus
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [LOG2NUMREGS:0]   NREGS   = (LOG2NUMREGS+1)'(NUMREGS);
    localparam logic [LOG2NUMREGS-1:0] LASTREG = LOG2NUMREGS'(NUMREGS-1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [LOG2NUMREGS-1:0]    r_clr_cnt;
    logic [LOG2NUMREGS-1:0]    w_clr_cnt_nxt;

    logic                      w_busy;
    logic                      w_rd_en;
    logic                      w_wr_en;
    logic [LOG2NUMREGS-1:0]    w_wr_addr;
    logic [WIDTH-1:0]          w_wr_data;

    logic [WIDTH-1:0]          r_mem [NUMREGS];
    logic [NUMRPORTS*WIDTH-1:0] r_rdout;
    logic [LOG2NUMREGS-1:0]    w_raddr [NUMRPORTS];
    logic [WIDTH-1:0]          w_rdval [NUMRPORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        unique case (r_state)
            CLEAR: begin
                if (r_clr_cnt == LASTREG) begin
                    w_state_nxt   = IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // The single write port is shared: the sequencer owns it while clearing.
    always_comb begin
        w_busy    = 1'b0;
        w_rd_en   = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = bus.c_reg;
        w_wr_data = bus.c_writedatain;
        if (r_state == CLEAR) begin
            w_busy    = 1'b1;
            w_wr_en   = 1'b1;
            w_wr_addr = r_clr_cnt;
            w_wr_data = CLEARVAL;
        end else begin
            w_rd_en = 1'b1;
            w_wr_en = bus.c_we && ({1'b0, bus.c_reg} < NREGS);
        end
    end

    assign bus.busy = w_busy;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUMRPORTS; i++) begin
            w_raddr[i] = bus.a_reg[i*LOG2NUMREGS +: LOG2NUMREGS];
            if ({1'b0, w_raddr[i]} >= NREGS) begin
                w_rdval[i] = CLEARVAL;
            end else if (BYPASS && w_wr_en && (w_wr_addr == w_raddr[i])) begin
                w_rdval[i] = w_wr_data;
            end else begin
                w_rdval[i] = r_mem[w_raddr[i]];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdout <= '0;
        end else if (w_rd_en) begin
            for (int unsigned i = 0; i < NUMRPORTS; i++) begin
                if (bus.a_en[i]) begin
                    r_rdout[i*WIDTH +: WIDTH] <= w_rdval[i];
                end
            end
        end
    end

    assign bus.a_readdataout = r_rdout;

endmodule
